// File: rtl/mac_job_arbiter_pkg.sv
// mac_arb_pkg: shared types, default parameters and helpers for the MAC job arbiter.
package mac_arb_pkg;
    typedef enum logic [2:0] {ARB, LOAD, RUN, WAIT, ACC, DONE} state_t;

    localparam int NUM_REQ_D = 4;
    localparam int WIDTH_D   = 8;
    localparam int LEN_W_D   = 4;
    localparam int ACC_W_D   = 20;
    localparam int MAX_REQ   = 8;

    function automatic logic [2:0] oh2idx(input logic [MAX_REQ-1:0] oh);
        oh2idx = '0;
        for (int i = 0; i < MAX_REQ; i++) if (oh[i]) oh2idx = 3'(i);
    endfunction
endpackage

// File: rtl/mac_job_arbiter_if.sv
// mac_job_arbiter_if: requester channels, multiplier channel and result port
// of the shared MAC arbiter; slave is the arbiter side.
interface mac_job_arbiter_if
    import mac_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_D,
    parameter int WIDTH   = WIDTH_D,
    parameter int LEN_W   = LEN_W_D,
    parameter int ACC_W   = ACC_W_D
);
    localparam int IDX_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ*WIDTH-1:0] op_a;
    logic [NUM_REQ*WIDTH-1:0] op_b;
    logic [NUM_REQ-1:0]       op_ack;
    logic [NUM_REQ-1:0]       grant;
    logic                     mul_start;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic                     mul_done;
    logic [2*WIDTH-1:0]       mul_product;
    logic                     res_valid;
    logic [IDX_W-1:0]         res_id;
    logic [ACC_W-1:0]         res_data;
    logic                     busy;

    modport slave (
        input  req_valid, req_len, op_a, op_b, mul_done, mul_product,
        output op_ack, grant, mul_start, mul_a, mul_b, res_valid, res_id, res_data, busy
    );
    modport master (
        output req_valid, req_len, op_a, op_b, mul_done, mul_product,
        input  op_ack, grant, mul_start, mul_a, mul_b, res_valid, res_id, res_data, busy
    );
endinterface

// File: rtl/mac_job_arbiter_rr_pick.sv
// mac_rr_pick: combinational round-robin picker; searches req & ~mask
// starting just after ptr and wrapping.
module mac_rr_pick
    import mac_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic          hit,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);
    logic [N-1:0] eff;

    // The second pass overrides the first, so anything above ptr wins over a wrap-around hit.
    always_comb begin
        eff = req & ~mask;
        onehot = '0;
        for (int i = N - 1; i >= 0; i--) if (eff[i] && i <= int'(ptr)) onehot = N'(1) << i;
        for (int i = N - 1; i >= 0; i--) if (eff[i] && i > int'(ptr)) onehot = N'(1) << i;
    end

    assign hit = |eff;
    assign idx = IW'(oh2idx(MAX_REQ'(onehot)));
endmodule

// File: rtl/mac_job_arbiter.sv
// mac_job_arbiter: grants requesters round-robin and sequences one shared
// shift-add multiplier through each job, returning the tagged accumulated sum.
module mac_job_arbiter
    import mac_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_D,
    parameter int WIDTH   = WIDTH_D,
    parameter int LEN_W   = LEN_W_D,
    parameter int ACC_W   = ACC_W_D
) (
    input  logic             clk,
    input  logic             reset,
    mac_job_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, res_id_q, res_id_d, pick_idx;
    logic [NUM_REQ-1:0] grant_q, grant_d, mask_q, mask_d, pick_oh;
    logic               pick_hit;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d, res_data_q, res_data_d, acc_sum;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;

    mac_rr_pick #(.N(NUM_REQ)) u_pick (
        .req    (bus.req_valid),
        .mask   (mask_q),
        .ptr    (rr_ptr_q),
        .hit    (pick_hit),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    assign acc_sum = acc_q + ACC_W'(prod_q);

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ARB;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     state_d = pick_hit ? LOAD : ARB;
            LOAD:    state_d = RUN;
            RUN:     state_d = WAIT;
            WAIT:    state_d = bus.mul_done ? ACC : WAIT;
            ACC:     state_d = (cnt_q == '0) ? DONE : LOAD;
            DONE:    state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        bus.op_ack    = (state_q == LOAD) ? grant_q : '0;
        bus.mul_start = state_q == RUN;
        bus.res_valid = state_q == DONE;
        bus.busy      = state_q != ARB;
    end

    assign bus.grant    = grant_q;
    assign bus.mul_a    = mul_a_q;
    assign bus.mul_b    = mul_b_q;
    assign bus.res_id   = res_id_q;
    assign bus.res_data = res_data_q;

    // rr_ptr doubles as the index of the job in flight; it only moves at grant.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        res_id_d   = res_id_q;
        res_data_d = res_data_q;
        mask_d     = '0;
        case (state_q)
            ARB: if (pick_hit) begin
                grant_d  = pick_oh;
                rr_ptr_d = pick_idx;
                cnt_d    = bus.req_len[pick_idx*LEN_W +: LEN_W];
                acc_d    = '0;
            end
            LOAD: begin
                mul_a_d = bus.op_a[rr_ptr_q*WIDTH +: WIDTH];
                mul_b_d = bus.op_b[rr_ptr_q*WIDTH +: WIDTH];
            end
            WAIT: if (bus.mul_done) prod_d = bus.mul_product;
            ACC: begin
                acc_d = acc_sum;
                if (cnt_q == '0) begin
                    res_id_d   = rr_ptr_q;
                    res_data_d = acc_sum;
                end else cnt_d = cnt_q - LEN_W'(1);
            end
            DONE: begin
                grant_d = '0;
                mask_d  = grant_q;
            end
            default: ;
        endcase
    end

    // The finished requester may still show req_valid in the ARB cycle after DONE; mask_q hides it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
            grant_q    <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            res_id_q   <= '0;
            res_data_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            res_id_q   <= res_id_d;
            res_data_q <= res_data_d;
        end
    end
endmodule
